// File: rtl/stage_mem.sv
// Memory-access pipeline stage: load/store handshake, load alignment,
// upstream freeze and registered write-back bundle.
module stage_mem #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter bit          ALIGN_ADDR = 1'b1
) (
    input  logic        clk_I,
    input  logic        rst,
    input  logic        Done_I,
    input  logic [31:0] PC_I,
    input  logic [5:0]  MCR_I,
    input  logic [31:0] WDR_I,
    input  logic [31:0] ASR_I,
    input  logic [4:0]  RAR_I,
    input  logic [2:0]  F3R_I,
    output logic [31:0] Address,
    output logic        MemWrite,
    output logic [31:0] Write_data,
    output logic [3:0]  Write_strb,
    output logic        MemRead,
    input  logic        Mem_Req_Ready,
    input  logic [31:0] Read_data,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ready,
    output logic        Feedback_Mem_Acc,
    output logic [31:0] PC_O,
    output logic        Done_O,
    output logic [4:0]  RWA_O,
    output logic [31:0] RWD_O
);

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        RREQ,
        RDW,
        FIN
    } state_t;

    state_t state;

    logic        mem_w;
    logic        mem_r;
    logic [4:0]  shamt;
    logic [31:0] sh;
    logic [31:0] load_word;

    assign mem_w = MCR_I[5];
    assign mem_r = MCR_I[4];

    // Request side is a pure function of the held EX->MEM registers.
    assign Address    = ALIGN_ADDR ? {ASR_I[31:2], 2'b00} : ASR_I;
    assign Write_data = WDR_I;
    assign Write_strb = MCR_I[3:0];

    // Handshake strobes follow the state; all forced low in reset.
    assign MemWrite        = rst && (state == WREQ);
    assign MemRead         = rst && (state == RREQ);
    assign Read_data_Ready = rst && (state == RDW);

    // Freeze upstream from the cycle an access is seen until it completes.
    assign Feedback_Mem_Acc = rst && (
        ((state == IDLE) && Done_I && (mem_w || mem_r)) ||
        (state == WREQ) || (state == RREQ) || (state == RDW));

    // Shift the addressed lane down, then extend per load width.
    always_comb begin
        shamt     = {ASR_I[1:0], 3'b000};
        sh        = Read_data >> shamt;
        load_word = Read_data;
        unique case (1'b1)
            (F3R_I == 3'b000): load_word = {{24{sh[7]}}, sh[7:0]};
            (F3R_I == 3'b001): load_word = {{16{sh[15]}}, sh[15:0]};
            (F3R_I == 3'b100): load_word = {24'd0, sh[7:0]};
            (F3R_I == 3'b101): load_word = {16'd0, sh[15:0]};
            default:           load_word = Read_data;
        endcase
    end

    // Access FSM and registered write-back bundle.
    always_ff @(posedge clk_I) begin
        if (!rst) begin
            state  <= IDLE;
            Done_O <= 1'b0;
            RWA_O  <= 5'd0;
            RWD_O  <= 32'd0;
            PC_O   <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Done_I && mem_w) begin
                        state  <= WREQ;
                        Done_O <= 1'b0;
                        RWA_O  <= 5'd0;
                    end else if (Done_I && mem_r) begin
                        state  <= RREQ;
                        Done_O <= 1'b0;
                        RWA_O  <= 5'd0;
                    end else begin
                        Done_O <= Done_I;
                        RWA_O  <= RAR_I;
                        RWD_O  <= ASR_I;
                        PC_O   <= PC_I;
                    end
                end
                WREQ: begin
                    Done_O <= 1'b0;
                    RWA_O  <= 5'd0;
                    if (Mem_Req_Ready)
                        state <= FIN;
                end
                RREQ: begin
                    Done_O <= 1'b0;
                    RWA_O  <= 5'd0;
                    if (Mem_Req_Ready)
                        state <= RDW;
                end
                RDW: begin
                    Done_O <= 1'b0;
                    RWA_O  <= 5'd0;
                    if (Read_data_Valid) begin
                        RWD_O <= load_word;
                        state <= FIN;
                    end
                end
                FIN: begin
                    Done_O <= 1'b1;
                    PC_O   <= PC_I;
                    state  <= IDLE;
                    if (mem_w) begin
                        RWA_O <= 5'd0;
                        RWD_O <= ASR_I;
                    end else begin
                        RWA_O <= RAR_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
